link_tx_framer: RTL and testbench

//  Transmit link-layer framer feeding one transceiver TX lane (tx_data/tx_header of a transceiver slot).

---
 rtl/link_tx_framer.sv | 210 +++++++++++++++++++++
 tb/tb_link_tx_framer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_tx_framer.sv
// Transmit link-layer framer: link-up alignment, idle fill, periodic alignment markers and EOF blocks.
// Optional DATA-payload scrambler (x^58+x^39+1) enabled by defining LINK_TX_SCRAMBLE_EN.
module link_tx_framer #(
    parameter int W         = 128,
    parameter int AM_PERIOD = 4096,
    parameter int ALIGN_CNT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         activate,
    input  logic         tx_pause,
    input  logic         s_valid,
    input  logic [0:W-1] s_data,
    input  logic         s_last,
    output logic         s_ready,
    output logic [0:W-1] tx_data,
    output logic [5:0]   tx_header,
    output logic         link_up,
    output logic         frame_abort
);
    localparam int AM_W = $clog2(AM_PERIOD);
    localparam int AC_W = $clog2(ALIGN_CNT + 1);

    localparam logic [5:0] HDR_DATA = 6'b000001;
    localparam logic [5:0] HDR_CTRL = 6'b000010;
    localparam logic [7:0] T_IDLE   = 8'h1E;
    localparam logic [7:0] T_ALIGN  = 8'h78;
    localparam logic [7:0] T_EOF    = 8'hE1;

    typedef enum logic [2:0] {
        ST_OFFLINE,
        ST_ALIGN,
        ST_IDLE,
        ST_DATA,
        ST_EOF
    } state_t;

    state_t            state_q, state_d;
    logic [0:W-1]      tx_data_q, tx_data_d;
    logic [5:0]        tx_header_q, tx_header_d;
    logic              link_up_q, link_up_d;
    logic              frame_abort_q, frame_abort_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [AM_W-1:0]   am_cnt_q, am_cnt_d;
    logic [AC_W-1:0]   align_cnt_q, align_cnt_d;
    logic [0:W-1]      payload;
    logic              am_due;
    logic              align_last;
    logic              handshake;

    function automatic logic [0:W-1] ctrl_block(input logic [7:0] blk_type, input logic [15:0] cnt);
        logic [0:W-1] b;
        b        = '0;
        b[0:7]   = blk_type;
        b[8:23]  = cnt;
        return b;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign am_due     = (am_cnt_q == AM_W'(AM_PERIOD - 1));
    assign align_last = (align_cnt_q == AC_W'(ALIGN_CNT - 1));
    assign s_ready    = ((state_q == ST_IDLE) || (state_q == ST_DATA)) && activate
                        && !tx_pause && !am_due;
    assign handshake  = s_valid && s_ready;

`ifdef LINK_TX_SCRAMBLE_EN
    logic [57:0]  scr_q, scr_d;
    logic [W+57:0] scr_res;

    // Self-synchronous: each output bit feeds back into the state, MSB-first.
    function automatic logic [W+57:0] scramble(input logic [0:W-1] din, input logic [57:0] s_in);
        logic [57:0]  s;
        logic [0:W-1] dout;
        s = s_in;
        for (int i = 0; i < W; i++) begin
            dout[i] = din[i] ^ s[38] ^ s[57];
            s       = {s[56:0], dout[i]};
        end
        return {s, dout};
    endfunction

    assign scr_res = scramble(s_data, scr_q);
    assign payload = scr_res[W-1:0];

    always_comb begin
        scr_d = scr_q;
        if (!activate || (state_q == ST_OFFLINE)) begin
            scr_d = '1;
        end else if (handshake) begin
            scr_d = scr_res[W+57:W];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scr_q <= '1;
        end else begin
            scr_q <= scr_d;
        end
    end
`else
    assign payload = s_data;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_OFFLINE;
        end else begin
            state_q <= state_d;
        end
    end

    // activate low exits to OFFLINE even while the gearbox pauses.
    always_comb begin
        state_d = state_q;
        if (!activate) begin
            state_d = ST_OFFLINE;
        end else if (!tx_pause) begin
            case (state_q)
                ST_OFFLINE: state_d = ST_ALIGN;
                ST_ALIGN:   if (align_last) state_d = ST_IDLE;
                ST_IDLE,
                ST_DATA:    if (handshake) state_d = s_last ? ST_EOF : ST_DATA;
                ST_EOF:     if (!am_due) state_d = ST_IDLE;
                default:    state_d = ST_OFFLINE;
            endcase
        end
    end

    always_comb begin
        tx_data_d     = tx_data_q;
        tx_header_d   = tx_header_q;
        link_up_d     = link_up_q;
        frame_abort_d = 1'b0;
        word_cnt_d    = word_cnt_q;
        am_cnt_d      = am_cnt_q;
        align_cnt_d   = align_cnt_q;
        if (!activate) begin
            tx_data_d     = ctrl_block(T_IDLE, 16'd0);
            tx_header_d   = HDR_CTRL;
            link_up_d     = 1'b0;
            frame_abort_d = (state_q == ST_DATA) || (state_q == ST_EOF);
            word_cnt_d    = '0;
            am_cnt_d      = '0;
            align_cnt_d   = '0;
        end else if (!tx_pause) begin
            tx_header_d = HDR_CTRL;
            tx_data_d   = ctrl_block(T_IDLE, 16'd0);
            case (state_q)
                ST_OFFLINE: begin
                    align_cnt_d = '0;
                    am_cnt_d    = '0;
                end
                ST_ALIGN: begin
                    tx_data_d = ctrl_block(T_ALIGN, 16'd0);
                    if (align_last) begin
                        link_up_d   = 1'b1;
                        align_cnt_d = '0;
                        am_cnt_d    = '0;
                    end else begin
                        align_cnt_d = align_cnt_q + 1'b1;
                    end
                end
                default: begin
                    // Marker takes priority over both a pending EOF and new data.
                    am_cnt_d = am_due ? '0 : am_cnt_q + 1'b1;
                    if (am_due) begin
                        tx_data_d = ctrl_block(T_ALIGN, 16'd0);
                    end else if (state_q == ST_EOF) begin
                        tx_data_d  = ctrl_block(T_EOF, word_cnt_q);
                        word_cnt_d = '0;
                    end else if (handshake) begin
                        tx_header_d = HDR_DATA;
                        tx_data_d   = payload;
                        word_cnt_d  = (state_q == ST_IDLE) ? 16'd1 : sat_inc(word_cnt_q);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_data_q     <= ctrl_block(T_IDLE, 16'd0);
            tx_header_q   <= HDR_CTRL;
            link_up_q     <= 1'b0;
            frame_abort_q <= 1'b0;
            word_cnt_q    <= '0;
            am_cnt_q      <= '0;
            align_cnt_q   <= '0;
        end else begin
            tx_data_q     <= tx_data_d;
            tx_header_q   <= tx_header_d;
            link_up_q     <= link_up_d;
            frame_abort_q <= frame_abort_d;
            word_cnt_q    <= word_cnt_d;
            am_cnt_q      <= am_cnt_d;
            align_cnt_q   <= align_cnt_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_header   = tx_header_q;
    assign link_up     = link_up_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_link_tx_framer.sv
// Self-checking bench for link_tx_framer: directed scenarios plus a randomized stream
// checked against a block-level reference model of the framing rules.
module tb_link_tx_framer;
    localparam int W         = 128;
    localparam int AM_PERIOD = 8;
    localparam int ALIGN_CNT = 6;

    localparam logic [5:0] HDR_DATA = 6'b000001;
    localparam logic [5:0] HDR_CTRL = 6'b000010;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         activate = 1'b0;
    logic         tx_pause = 1'b0;
    logic         s_valid = 1'b0;
    logic [0:W-1] s_data = '0;
    logic         s_last = 1'b0;
    logic         s_ready;
    logic [0:W-1] tx_data;
    logic [5:0]   tx_header;
    logic         link_up;
    logic         frame_abort;

    int checks = 0;
    int errors = 0;
    int np_cnt = 0;

    logic         rdy_s;
    logic [0:W-1] o_data;
    logic [5:0]   o_hdr;
    logic         o_lu;
    logic         o_ab;

`ifdef LINK_TX_SCRAMBLE_EN
    logic [57:0] dsc = '1;
`endif

    link_tx_framer #(.W(W), .AM_PERIOD(AM_PERIOD), .ALIGN_CNT(ALIGN_CNT)) dut (
        .clock(clock), .reset(reset), .activate(activate), .tx_pause(tx_pause),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .tx_data(tx_data), .tx_header(tx_header), .link_up(link_up), .frame_abort(frame_abort)
    );

    always #5 clock = ~clock;

    function automatic logic [0:W-1] ctrl_blk(input logic [7:0] t, input logic [15:0] c);
        logic [0:W-1] b;
        b       = '0;
        b[0:7]  = t;
        b[8:23] = c;
        return b;
    endfunction

    function automatic logic [0:W-1] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Recovers the upstream word from a DATA block (reference descrambler when scrambling is on).
    function automatic logic [0:W-1] rx_payload(input logic [0:W-1] blk);
`ifdef LINK_TX_SCRAMBLE_EN
        logic [0:W-1] r;
        for (int i = 0; i < W; i++) begin
            r[i] = blk[i] ^ dsc[38] ^ dsc[57];
            dsc  = {dsc[56:0], blk[i]};
        end
        return r;
`else
        return blk;
`endif
    endfunction

    task automatic step(input logic act, input logic v, input logic [0:W-1] d,
                        input logic l, input logic p);
        @(negedge clock);
        activate = act; s_valid = v; s_data = d; s_last = l; tx_pause = p;
        #1;
        rdy_s = s_ready;
        @(posedge clock);
        #1;
        o_data = tx_data; o_hdr = tx_header; o_lu = link_up; o_ab = frame_abort;
        if (!p) np_cnt++;
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_am_start();
        while ((np_cnt % AM_PERIOD) != 0) idle_step();
    endtask

    task automatic test_reset();
        reset = 1'b0; activate = 1'b1; s_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (tx_header !== HDR_CTRL) begin errors++; $display("FAIL reset_hdr got %b want %b", tx_header, HDR_CTRL); end
        checks++; if (tx_data !== ctrl_blk(8'h1E, 16'd0)) begin errors++; $display("FAIL reset_data got %h", tx_data); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", s_ready); end
        checks++; if (link_up !== 1'b0 || frame_abort !== 1'b0) begin errors++; $display("FAIL reset_flags lu %b ab %b want 0 0", link_up, frame_abort); end
        @(negedge clock);
        activate = 1'b0; s_valid = 1'b0; reset = 1'b1;
    endtask

    task automatic test_link_up();
        int aligns = 0;
        bit up = 0;
`ifdef LINK_TX_SCRAMBLE_EN
        dsc = '1;
`endif
        for (int c = 0; c < 3 * ALIGN_CNT + 10; c++) begin
            idle_step();
            if (o_hdr === HDR_CTRL && o_data === ctrl_blk(8'h78, 16'd0)) aligns++;
            if (o_lu === 1'b1) begin up = 1; break; end
        end
        checks++; if (!up) begin errors++; $display("FAIL link_up_timeout link_up never rose"); end
        checks++; if (aligns != ALIGN_CNT) begin errors++; $display("FAIL align_count got %0d want %0d", aligns, ALIGN_CNT); end
        np_cnt = 0;
        idle_step();
        checks++; if (o_hdr !== HDR_CTRL || o_data !== ctrl_blk(8'h1E, 16'd0) || o_lu !== 1'b1) begin
            errors++; $display("FAIL post_align_idle hdr %b data %h lu %b want idle lu=1", o_hdr, o_data, o_lu);
        end
    endtask

    task automatic test_frame3();
        logic [0:W-1] w [3];
        foreach (w[i]) w[i] = rnd_word();
        wait_am_start();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, w[i], (i == 2), 1'b0);
            checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL frame3_ready%0d got %b want 1", i, rdy_s); end
            checks++; if (o_hdr !== HDR_DATA || rx_payload(o_data) !== w[i]) begin
                errors++; $display("FAIL frame3_data%0d hdr %b data %h want %h", i, o_hdr, o_data, w[i]);
            end
        end
        idle_step();
        checks++; if (o_hdr !== HDR_CTRL || o_data !== ctrl_blk(8'hE1, 16'd3)) begin
            errors++; $display("FAIL frame3_eof hdr %b data %h want EOF count 3", o_hdr, o_data);
        end
    endtask

    task automatic test_pause();
        logic [0:W-1] a, b, c, held;
        a = rnd_word(); b = rnd_word(); c = rnd_word();
        wait_am_start();
        step(1'b1, 1'b1, a, 1'b0, 1'b0);
        held = o_data;
        checks++; if (o_hdr !== HDR_DATA || rx_payload(o_data) !== a) begin errors++; $display("FAIL pause_a data %h want %h", o_data, a); end
        step(1'b1, 1'b1, b, 1'b0, 1'b1);
        checks++; if (rdy_s !== 1'b0) begin errors++; $display("FAIL pause_ready got %b want 0", rdy_s); end
        checks++; if (o_hdr !== HDR_DATA || o_data !== held) begin errors++; $display("FAIL pause_hold data %h want %h", o_data, held); end
        step(1'b1, 1'b1, b, 1'b0, 1'b0);
        checks++; if (o_hdr !== HDR_DATA || rx_payload(o_data) !== b) begin errors++; $display("FAIL pause_b data %h want %h", o_data, b); end
        step(1'b1, 1'b1, c, 1'b1, 1'b0);
        checks++; if (o_hdr !== HDR_DATA || rx_payload(o_data) !== c) begin errors++; $display("FAIL pause_c data %h want %h", o_data, c); end
        idle_step();
        checks++; if (o_data !== ctrl_blk(8'hE1, 16'd3)) begin errors++; $display("FAIL pause_eof data %h want EOF count 3", o_data); end
    endtask

    task automatic test_back_to_back();
        logic [0:W-1] x, y;
        x = rnd_word(); y = rnd_word();
        wait_am_start();
        step(1'b1, 1'b1, x, 1'b1, 1'b0);
        checks++; if (o_hdr !== HDR_DATA || rx_payload(o_data) !== x) begin errors++; $display("FAIL b2b_x data %h want %h", o_data, x); end
        step(1'b1, 1'b1, y, 1'b1, 1'b0);
        checks++; if (rdy_s !== 1'b0 || o_data !== ctrl_blk(8'hE1, 16'd1)) begin errors++; $display("FAIL b2b_eof1 rdy %b data %h want 0 EOF1", rdy_s, o_data); end
        step(1'b1, 1'b1, y, 1'b1, 1'b0);
        checks++; if (o_hdr !== HDR_DATA || rx_payload(o_data) !== y) begin errors++; $display("FAIL b2b_y data %h want %h", o_data, y); end
        idle_step();
        checks++; if (o_data !== ctrl_blk(8'hE1, 16'd1)) begin errors++; $display("FAIL b2b_eof2 data %h want EOF1", o_data); end
    endtask

    // Block-level model: markers on every AM_PERIOD-th unpaused cycle, EOF right after the last
    // word of a frame, accepted words in order, idle fill otherwise, everything frozen on pause.
    task automatic test_stream(input int pause_pct, input int valid_pct, input int ncycles, input int maxlen);
        bit have = 0, last = 0, eof_pend = 0, done = 0, p, marker, hs, exp_rdy;
        logic [0:W-1] word = '0, prev_d, exp_d;
        logic [5:0] prev_h, exp_h;
        int rem = 0, frame_cnt = 0, eof_cnt = 0, markers = 0;
        for (int c = 0; c < ncycles + 200; c++) begin
            if (c >= ncycles && !have && rem == 0 && !eof_pend) begin done = 1; break; end
            if (!have && (c < ncycles || rem > 0) && $urandom_range(99) < valid_pct) begin
                if (rem == 0) rem = $urandom_range(maxlen, 1);
                rem--;
                have = 1; word = rnd_word(); last = (rem == 0);
            end
            p = ($urandom_range(99) < pause_pct);
            marker = !p && ((np_cnt % AM_PERIOD) == AM_PERIOD - 1);
            exp_rdy = !p && !marker && !eof_pend;
            prev_d = o_data; prev_h = o_hdr;
            step(1'b1, have, word, last, p);
            checks++; if (rdy_s !== exp_rdy) begin errors++; $display("FAIL stream_ready cyc %0d got %b want %b", c, rdy_s, exp_rdy); end
            hs = have && exp_rdy;
            exp_h = HDR_CTRL; exp_d = ctrl_blk(8'h1E, 16'd0);
            if (p) begin
                exp_h = prev_h; exp_d = prev_d;
            end else if (marker) begin
                exp_d = ctrl_blk(8'h78, 16'd0); markers++;
            end else if (eof_pend) begin
                exp_d = ctrl_blk(8'hE1, 16'(eof_cnt)); eof_pend = 0;
            end else if (hs) begin
                exp_h = HDR_DATA; exp_d = word; frame_cnt++;
                if (last) begin eof_pend = 1; eof_cnt = frame_cnt; frame_cnt = 0; end
            end
            if (hs) have = 0;
            if (exp_h == HDR_DATA && !p) begin
                checks++; if (o_hdr !== HDR_DATA || rx_payload(o_data) !== exp_d) begin
                    errors++; $display("FAIL stream_data cyc %0d hdr %b data %h want %h", c, o_hdr, o_data, exp_d);
                end
            end else begin
                checks++; if (o_hdr !== exp_h || o_data !== exp_d) begin
                    errors++; $display("FAIL stream_block cyc %0d hdr %b data %h want %b %h", c, o_hdr, o_data, exp_h, exp_d);
                end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL stream_drain frame still open at cycle budget"); end
        checks++; if (markers == 0) begin errors++; $display("FAIL stream_markers got 0 want >0"); end
    endtask

    task automatic test_abort();
        wait_am_start();
        step(1'b1, 1'b1, rnd_word(), 1'b0, 1'b0);
        step(1'b1, 1'b1, rnd_word(), 1'b0, 1'b0);
        step(1'b0, 1'b1, rnd_word(), 1'b0, 1'b0);
        checks++; if (rdy_s !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", rdy_s); end
        checks++; if (o_ab !== 1'b1 || o_lu !== 1'b0) begin errors++; $display("FAIL abort_pulse ab %b lu %b want 1 0", o_ab, o_lu); end
        checks++; if (o_hdr !== HDR_CTRL || o_data !== ctrl_blk(8'h1E, 16'd0)) begin errors++; $display("FAIL abort_idle data %h want IDLE", o_data); end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_ab !== 1'b0 || o_data !== ctrl_blk(8'h1E, 16'd0)) begin errors++; $display("FAIL abort_after ab %b data %h want 0 IDLE", o_ab, o_data); end
    endtask

    task automatic test_reset_midframe();
        wait_am_start();
        step(1'b1, 1'b1, rnd_word(), 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (tx_header !== HDR_CTRL || tx_data !== ctrl_blk(8'h1E, 16'd0)) begin errors++; $display("FAIL rstmid_block data %h want IDLE", tx_data); end
        checks++; if (link_up !== 1'b0 || frame_abort !== 1'b0) begin errors++; $display("FAIL rstmid_flags lu %b ab %b want 0 0", link_up, frame_abort); end
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (o_ab !== 1'b0) begin errors++; $display("FAIL rstmid_noabort ab %b want 0", o_ab); end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_frame3();
        test_pause();
        test_back_to_back();
        test_stream(0, 100, 120, 20);
        test_stream(20, 70, 400, 5);
        test_abort();
        test_link_up();
        test_stream(15, 80, 150, 4);
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
